// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder with data-phase response multiplexer and a built-in
// default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahblite_decoder_mux #(
    parameter int                  NPORT     = 5,
    parameter logic [NPORT*32-1:0] PORT_BASE = {32'h4000_0020, 32'h4000_0010, 32'h4001_0000,
                                                32'h2000_0000, 32'h0000_0000},
    parameter logic [NPORT*32-1:0] PORT_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000,
                                                32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [NPORT-1:0]    PORT_EN   = '1,
    parameter int                  CNT_W     = 8
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    output logic [NPORT-1:0]    HSEL,
    input  logic [NPORT-1:0]    HREADYOUT_S,
    input  logic [NPORT-1:0]    HRESP_S,
    input  logic [NPORT*32-1:0] HRDATA_S,
    output logic                HREADY,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    input  logic                ERR_CLR,
    output logic                ERR_VALID,
    output logic [31:0]         ERR_ADDR,
    output logic [CNT_W-1:0]    ERR_CNT
);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } dflt_state_t;

    logic [NPORT-1:0] match;
    logic             unmapped;
    logic             xfer_active;
    logic             err_start;
    logic             found;

    logic [NPORT-1:0] dsel_port;
    logic             dsel_def;

    logic             mux_hready;
    logic             mux_hresp;
    logic [31:0]      mux_hrdata;

    dflt_state_t      state;
    dflt_state_t      state_nxt;
    logic             fsm_hready;
    logic             fsm_hresp;

    logic [CNT_W-1:0] err_cnt;
    logic [31:0]      err_addr;
    logic             err_valid;

    // Address decode: lowest matching index wins when windows overlap.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        match = '0;
        HSEL  = '0;
        found = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            match[i] = PORT_EN[i] && ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
        end
        for (int i = 0; i < NPORT; i++) begin
            if (match[i] && !found) begin
                HSEL[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign unmapped    = ~|match;
    assign xfer_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign err_start   = HREADY && xfer_active && unmapped;

    always_comb begin
        mux_hready = 1'b1;
        mux_hresp  = 1'b0;
        mux_hrdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel_port[i]) begin
                mux_hready = HREADYOUT_S[i];
                mux_hresp  = HRESP_S[i];
                mux_hrdata = HRDATA_S[32*i +: 32];
            end
        end
    end

    assign HREADY = dsel_def ? fsm_hready : mux_hready;
    assign HRESP  = dsel_def ? fsm_hresp  : mux_hresp;
    assign HRDATA = dsel_def ? 32'h0      : mux_hrdata;

    // Default slave: ERR1 stalls with ERROR, ERR2 completes it.
    always_comb begin
        state_nxt  = state;
        fsm_hready = 1'b1;
        fsm_hresp  = 1'b0;
        case (state)
            DS_IDLE: begin
                if (err_start) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                fsm_hready = 1'b0;
                fsm_hresp  = 1'b1;
                state_nxt  = DS_ERR2;
            end
            DS_ERR2: begin
                fsm_hresp = 1'b1;
                state_nxt = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register samples the values
        // that were present before this edge, independent of statement order.
        if (HRESET) begin
            state     <= DS_IDLE;
            dsel_port <= '0;
            dsel_def  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (HREADY) begin
                dsel_port <= HSEL;
                dsel_def  <= unmapped;
            end
        end
    end

    // A new error entry takes precedence over a coincident clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_cnt   <= '0;
            err_addr  <= '0;
            err_valid <= 1'b0;
        end else if (err_start) begin
            if (ERR_CLR) begin
                err_cnt <= CNT_W'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (ERR_CLR || !err_valid) begin
                err_addr <= HADDR;
            end
            err_valid <= 1'b1;
        end else if (ERR_CLR) begin
            err_cnt   <= '0;
            err_addr  <= '0;
            err_valid <= 1'b0;
        end
    end

    assign ERR_CNT   = err_cnt;
    assign ERR_ADDR  = err_addr;
    assign ERR_VALID = err_valid;

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Self-checking bench for ahblite_decoder_mux: scoreboard of expected data-phase
// responses plus two extra instances for disabled-port and overlap decoding.
module tb_ahblite_decoder_mux;

    localparam int         NPORT    = 5;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        hready;
        logic        hresp;
        logic        chk;
        logic [31:0] hrdata;
    } resp_t;

    logic                hclk = 1'b0;
    logic                hreset;
    logic [31:0]         haddr;
    logic [1:0]          htrans;
    logic [NPORT-1:0]    hreadyout_s;
    logic [NPORT-1:0]    hresp_s;
    logic [NPORT*32-1:0] hrdata_s;
    logic                err_clr;

    logic [NPORT-1:0] hsel, hsel_en, hsel_ov;
    logic             hready, hready_en, hready_ov;
    logic             hresp, hresp_en, hresp_ov;
    logic [31:0]      hrdata, hrdata_en, hrdata_ov;
    logic             err_valid, err_valid_en, err_valid_ov;
    logic [31:0]      err_addr, err_addr_en, err_addr_ov;
    logic [7:0]       err_cnt, err_cnt_en, err_cnt_ov;

    resp_t exp_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    always #5 hclk = ~hclk;

    ahblite_decoder_mux dut (
        .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
        .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
        .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .ERR_CLR(err_clr),
        .ERR_VALID(err_valid), .ERR_ADDR(err_addr), .ERR_CNT(err_cnt)
    );

    ahblite_decoder_mux #(.PORT_EN(5'b11110)) dut_en (
        .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel_en),
        .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
        .HREADY(hready_en), .HRESP(hresp_en), .HRDATA(hrdata_en), .ERR_CLR(err_clr),
        .ERR_VALID(err_valid_en), .ERR_ADDR(err_addr_en), .ERR_CNT(err_cnt_en)
    );

    ahblite_decoder_mux #(
        .PORT_BASE({32'h4000_0020, 32'h4000_0010, 32'h4001_0000, 32'h2000_0000, 32'h2000_0000})
    ) dut_ov (
        .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel_ov),
        .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
        .HREADY(hready_ov), .HRESP(hresp_ov), .HRDATA(hrdata_ov), .ERR_CLR(err_clr),
        .ERR_VALID(err_valid_ov), .ERR_ADDR(err_addr_ov), .ERR_CNT(err_cnt_ov)
    );

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        @(negedge hclk);
    endtask

    task automatic sb_push(input logic rdy, input logic rsp, input logic chk, input logic [31:0] d);
        resp_t r;
        r.valid  = 1'b1;
        r.hready = rdy;
        r.hresp  = rsp;
        r.chk    = chk;
        r.hrdata = d;
        exp_q.push_back(r);
    endtask

    task automatic sb_pop(output resp_t e);
        if (exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        haddr  = 32'h2000_0004;
        htrans = T_IDLE;
        repeat (2) @(posedge hclk);
        settle();
        n_run++;
        if ({hsel, hready, hresp, hrdata} !== {5'b00010, 1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: HSEL=%b HREADY=%0b HRESP=%0b HRDATA=%h, want 00010 1 0 00000000",
                     hsel, hready, hresp, hrdata);
        end
        n_run++;
        if ({err_valid, err_addr, err_cnt} !== {1'b0, 32'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_log: VALID=%0b ADDR=%h CNT=%0d, want 0 00000000 0",
                     err_valid, err_addr, err_cnt);
        end
        next_cycle();
        hreset = 1'b0;
    endtask

    task automatic test_routing();
        resp_t e;
        haddr  = 32'h4001_0008;
        htrans = T_NONSEQ;
        settle();
        n_run++;
        if (hsel !== 5'b00100) begin
            n_fail++;
            $display("FAIL route_hsel: HSEL=%b, want 00100", hsel);
        end
        sb_push(1'b0, 1'b0, 1'b0, 32'h0);
        sb_push(1'b0, 1'b0, 1'b0, 32'h0);
        sb_push(1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5);
        sb_push(1'b1, 1'b0, 1'b1, 32'h2222_2222);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            case (c)
                0, 1: begin
                    hreadyout_s[2]    = 1'b0;
                    hrdata_s[64 +: 32] = 32'hDEAD_0002;
                    haddr             = 32'h2000_0000;
                    htrans            = T_NONSEQ;
                end
                2: begin
                    hreadyout_s[2]    = 1'b1;
                    hrdata_s[64 +: 32] = 32'hA5A5_A5A5;
                end
                default: begin
                    haddr  = 32'h3000_0000;
                    htrans = T_IDLE;
                end
            endcase
            settle();
            sb_pop(e);
            n_run++;
            if (!e.valid || hready !== e.hready || hresp !== e.hresp || (e.chk && hrdata !== e.hrdata)) begin
                n_fail++;
                $display("FAIL route_dphase%0d: HREADY=%0b HRESP=%0b HRDATA=%h, want HREADY=%0b HRESP=%0b HRDATA=%h (entry %0b)",
                         c, hready, hresp, hrdata, e.hready, e.hresp, e.hrdata, e.valid);
            end
        end
    endtask

    task automatic test_unmapped_error();
        resp_t e;
        next_cycle();
        haddr  = 32'h3000_0000;
        htrans = T_NONSEQ;
        settle();
        n_run++;
        if (hsel !== 5'b00000) begin
            n_fail++;
            $display("FAIL unmapped_hsel: HSEL=%b, want 00000", hsel);
        end
        sb_push(1'b0, 1'b1, 1'b1, 32'h0);
        sb_push(1'b1, 1'b1, 1'b1, 32'h0);
        next_cycle();
        htrans = T_IDLE;
        settle();
        sb_pop(e);
        n_run++;
        if (!e.valid || hready !== e.hready || hresp !== e.hresp || (e.chk && hrdata !== e.hrdata)) begin
            n_fail++;
            $display("FAIL unmapped_err1: HREADY=%0b HRESP=%0b HRDATA=%h, want HREADY=%0b HRESP=%0b HRDATA=%h (entry %0b)",
                     hready, hresp, hrdata, e.hready, e.hresp, e.hrdata, e.valid);
        end
        n_run++;
        if ({err_valid, err_addr, err_cnt} !== {1'b1, 32'h3000_0000, 8'd1}) begin
            n_fail++;
            $display("FAIL unmapped_log: VALID=%0b ADDR=%h CNT=%0d, want 1 30000000 1",
                     err_valid, err_addr, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        resp_t e;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            case (c)
                0: begin
                    haddr  = 32'h5000_0000;
                    htrans = T_NONSEQ;
                end
                default: htrans = T_IDLE;
            endcase
            settle();
            sb_pop(e);
            n_run++;
            if (!e.valid || hready !== e.hready || hresp !== e.hresp || (e.chk && hrdata !== e.hrdata)) begin
                n_fail++;
                $display("FAIL b2b_dphase%0d: HREADY=%0b HRESP=%0b HRDATA=%h, want HREADY=%0b HRESP=%0b HRDATA=%h (entry %0b)",
                         c, hready, hresp, hrdata, e.hready, e.hresp, e.hrdata, e.valid);
            end
            if (c == 0) begin
                sb_push(1'b0, 1'b1, 1'b1, 32'h0);
                sb_push(1'b1, 1'b1, 1'b1, 32'h0);
            end
            if (c == 2) sb_push(1'b1, 1'b0, 1'b1, 32'h0);
            if (c == 1 || c == 3) begin
                n_run++;
                if ({err_valid, err_addr, err_cnt} !== {1'b1, 32'h3000_0000, 8'd2}) begin
                    n_fail++;
                    $display("FAIL b2b_log%0d: VALID=%0b ADDR=%h CNT=%0d, want 1 30000000 2",
                             c, err_valid, err_addr, err_cnt);
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        resp_t e;
        next_cycle();
        err_clr = 1'b1;
        htrans  = T_IDLE;
        next_cycle();
        err_clr = 1'b0;
        settle();
        n_run++;
        if ({err_valid, err_addr, err_cnt} !== {1'b0, 32'h0, 8'd0}) begin
            n_fail++;
            $display("FAIL clear_only: VALID=%0b ADDR=%h CNT=%0d, want 0 00000000 0",
                     err_valid, err_addr, err_cnt);
        end
        next_cycle();
        haddr   = 32'h6000_0000;
        htrans  = T_NONSEQ;
        err_clr = 1'b1;
        settle();
        sb_push(1'b0, 1'b1, 1'b1, 32'h0);
        sb_push(1'b1, 1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            err_clr = 1'b0;
            htrans  = T_IDLE;
            settle();
            sb_pop(e);
            n_run++;
            if (!e.valid || hready !== e.hready || hresp !== e.hresp || (e.chk && hrdata !== e.hrdata)) begin
                n_fail++;
                $display("FAIL clear_dphase%0d: HREADY=%0b HRESP=%0b HRDATA=%h, want HREADY=%0b HRESP=%0b HRDATA=%h (entry %0b)",
                         c, hready, hresp, hrdata, e.hready, e.hresp, e.hrdata, e.valid);
            end
        end
        n_run++;
        if ({err_valid, err_addr, err_cnt} !== {1'b1, 32'h6000_0000, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_vs_error: VALID=%0b ADDR=%h CNT=%0d, want 1 60000000 1",
                     err_valid, err_addr, err_cnt);
        end
    endtask

    task automatic test_saturation();
        resp_t e;
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            if (i == 0) begin
                haddr  = 32'h7000_0000;
                htrans = T_NONSEQ;
            end
            settle();
            if (i > 0) begin
                sb_pop(e);
                n_run++;
                if (!e.valid || hready !== e.hready || hresp !== e.hresp || (e.chk && hrdata !== e.hrdata)) begin
                    n_fail++;
                    $display("FAIL sat_dphase%0d: HREADY=%0b HRESP=%0b, want HREADY=%0b HRESP=%0b (entry %0b)",
                             i, hready, hresp, e.hready, e.hresp, e.valid);
                end
            end
            if (i % 2 == 0) begin
                sb_push(1'b0, 1'b1, 1'b1, 32'h0);
                sb_push(1'b1, 1'b1, 1'b1, 32'h0);
            end
        end
        next_cycle();
        htrans = T_IDLE;
        settle();
        sb_pop(e);
        n_run++;
        if (!e.valid || hready !== e.hready || hresp !== e.hresp) begin
            n_fail++;
            $display("FAIL sat_last: HREADY=%0b HRESP=%0b, want HREADY=%0b HRESP=%0b (entry %0b)",
                     hready, hresp, e.hready, e.hresp, e.valid);
        end
        n_run++;
        if ({err_valid, err_addr, err_cnt} !== {1'b1, 32'h6000_0000, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_log: VALID=%0b ADDR=%h CNT=%0d, want 1 60000000 255",
                     err_valid, err_addr, err_cnt);
        end
    endtask

    task automatic test_port_en();
        next_cycle();
        hreset = 1'b1;
        htrans = T_IDLE;
        next_cycle();
        hreset = 1'b0;
        haddr  = 32'h0000_0100;
        htrans = T_NONSEQ;
        settle();
        n_run++;
        if ({hsel, hsel_en} !== {5'b00001, 5'b00000}) begin
            n_fail++;
            $display("FAIL en_hsel: HSEL=%b HSEL_EN=%b, want 00001 00000", hsel, hsel_en);
        end
        next_cycle();
        htrans = T_IDLE;
        settle();
        n_run++;
        if ({hready, hresp, hrdata, hready_en, hresp_en} !== {1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL en_err1: main %0b/%0b/%h disabled %0b/%0b, want 1/0/11111111 and 0/1",
                     hready, hresp, hrdata, hready_en, hresp_en);
        end
        next_cycle();
        settle();
        n_run++;
        if ({hready_en, hresp_en, err_addr_en, err_cnt_en, err_cnt} !==
            {1'b1, 1'b1, 32'h0000_0100, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL en_err2: disabled %0b/%0b ADDR=%h CNT=%0d main CNT=%0d, want 1/1 00000100 1, 0",
                     hready_en, hresp_en, err_addr_en, err_cnt_en, err_cnt);
        end
    endtask

    task automatic test_decode_map();
        logic [31:0] addrs [6];
        logic [4:0]  want  [6];
        addrs = '{32'h2000_0010, 32'h4000_0014, 32'h4000_002C, 32'h4000_0030, 32'h4001_FFFC, 32'h0000_FFFF};
        want  = '{5'b00010, 5'b01000, 5'b10000, 5'b00000, 5'b00100, 5'b00001};
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            htrans = T_IDLE;
            haddr  = addrs[k];
            settle();
            n_run++;
            if (hsel !== want[k]) begin
                n_fail++;
                $display("FAIL decode_%h: HSEL=%b, want %b", addrs[k], hsel, want[k]);
            end
            if (k == 0) begin
                n_run++;
                if (hsel_ov !== 5'b00001) begin
                    n_fail++;
                    $display("FAIL overlap_prio: HSEL=%b, want 00001", hsel_ov);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        resp_t e;
        next_cycle();
        haddr  = 32'h3000_0000;
        htrans = T_NONSEQ;
        settle();
        sb_push(1'b0, 1'b1, 1'b1, 32'h0);
        next_cycle();
        htrans = T_IDLE;
        hreset = 1'b1;
        settle();
        sb_pop(e);
        n_run++;
        if (!e.valid || hready !== e.hready || hresp !== e.hresp) begin
            n_fail++;
            $display("FAIL rstmid_err1: HREADY=%0b HRESP=%0b, want HREADY=%0b HRESP=%0b (entry %0b)",
                     hready, hresp, e.hready, e.hresp, e.valid);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            hreset = 1'b0;
            settle();
            n_run++;
            if ({hready, hresp, hrdata, err_cnt} !== {1'b1, 1'b0, 32'h0, 8'd0}) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: HREADY=%0b HRESP=%0b HRDATA=%h CNT=%0d, want 1 0 00000000 0",
                         c, hready, hresp, hrdata, err_cnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset      = 1'b1;
        haddr       = '0;
        htrans      = T_IDLE;
        hreadyout_s = '1;
        hresp_s     = '0;
        hrdata_s    = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        err_clr     = 1'b0;

        test_reset();
        test_routing();
        test_unmapped_error();
        test_back_to_back();
        test_clear_priority();
        test_saturation();
        test_port_en();
        test_decode_map();
        test_reset_mid();

        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ahblite_decoder_mux.md
# ahblite_decoder_mux

Parametrised AHB-Lite address decoder with integrated slave response multiplexer and default (error) slave. It sits between the single AHB-Lite master and up to eight slave ports. It produces address-phase HSEL, registers the data-phase selection, and returns the selected slave's HRDATA/HREADY/HRESP. Accesses to unmapped addresses receive a protocol-correct two-cycle ERROR response and are logged for software.

## Interface
- NPORT, 5: number of slave ports, 1..8.
- PORT_BASE, {0x40000020, 0x40000010, 0x40010000, 0x20000000, 0x00000000}: NPORT×32 packed base addresses; port i occupies bits [32i+31:32i].
- PORT_MASK, {0xFFFFFFF0, 0xFFFFFFF0, 0xFFFF0000, 0xFFFF0000, 0xFFFF0000}: NPORT×32 packed masks. Port i matches when (HADDR & MASK_i) == BASE_i.
- PORT_EN, all ones: NPORT-bit enable. A disabled port never matches.
- CNT_W, 8: width of the error counter.

Ports:
- HCLK  in  1  system clock. Single clock domain; everything is sampled on its rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type. Bit 1 set means NONSEQ or SEQ.
- HSEL  out  NPORT  address-phase slave selects, combinational, at most one bit set.
- HREADYOUT_S  in  NPORT  per-slave ready, packed.
- HRESP_S  in  NPORT  per-slave response, packed.
- HRDATA_S  in  NPORT×32  per-slave read data, packed.
- HREADY  out  1  bus ready, fed to the master and to all slaves.
- HRESP  out  1  bus response to the master.
- HRDATA  out  32  bus read data to the master.
- ERR_CLR  in  1  single-cycle pulse that clears the error log.
- ERR_VALID  out  1  high while ERR_ADDR holds a logged address.
- ERR_ADDR  out  32  address of the first unmapped active transfer since the last clear.
- ERR_CNT  out  CNT_W  saturating count of unmapped active transfers.

## Operation
- **Decode**
  - HSEL[i] = PORT_EN[i] & match_i & no match on any lower index.
  - Lowest index wins on overlapping windows.
  - HSEL is driven regardless of HTRANS; slaves qualify it with HTRANS.
- **Unmapped** means no port matches.
- **Data-phase select register (dsel)**
  - Holds one-hot port bits plus a default flag.
  - Loaded from the decode result only when HREADY=1 at the clock edge.
  - Held otherwise.
- **Output mux when dsel selects port i:** HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i], HRDATA = HRDATA_S[i].
- **Output mux when no port is selected:** outputs come from the default slave FSM. HRDATA = 0 throughout.
- **Default slave FSM states**
  - IDLE: HREADY=1, HRESP=0.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- **FSM transitions**
  - IDLE → ERR1 when HREADY=1 & HTRANS[1]=1 & unmapped.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 when HREADY=1 & HTRANS[1]=1 & unmapped. Since HREADY=1 in ERR2, this covers back-to-back errors.
  - ERR2 → IDLE otherwise.
- **IDLE/BUSY to an unmapped address:** zero-wait OKAY. No FSM transition, no log entry.
- **Error log**, updated on every entry into ERR1:
  - ERR_CNT increments, saturating at 2^CNT_W−1.
  - If ERR_VALID=0, ERR_ADDR is loaded with HADDR and ERR_VALID is set.
  - If ERR_VALID=1, ERR_ADDR is held (first error is sticky).
- **ERR_CLR**
  - Zeroes ERR_CNT, ERR_VALID and ERR_ADDR.
  - If it coincides with a new error entry, the new error wins: ERR_CNT=1, ERR_VALID=1, ERR_ADDR=new HADDR.

## Timing
- **Reset**, effective at the first HCLK edge with HRESET=1:
  - dsel = none, FSM = IDLE.
  - HREADY=1, HRESP=0, HRDATA=0.
  - ERR_CNT=0, ERR_ADDR=0, ERR_VALID=0.
  - HSEL still follows HADDR combinationally.
- **Reset mid-transfer**, including in ERR1 or ERR2: the FSM returns to IDLE and dsel to none at that edge. No further ERROR cycle is emitted.
- **Latency**
  - HSEL: 0 cycles from HADDR.
  - Response mux: 0 cycles from slave outputs; the data-phase select is registered 1 cycle after the address phase.
  - Unmapped active transfer: exactly 2 data-phase cycles, ERR1 then ERR2.
- **Wait states:** a slave holding HREADYOUT=0 freezes dsel. The next address phase is not sampled until HREADY=1.
- **Combinational paths:** there is no path from HREADYOUT_S to HSEL. The only combinational path to HREADY is from HREADYOUT_S through the mux.

## Test plan
- **Reset:** assert HRESET for 2 cycles with HADDR=0x20000004 → HSEL=5'b00010, HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0.
- **Routing with wait states**
  - Stimulus: NONSEQ to 0x40010008. In the next cycle, slave 2 drives HREADYOUT=0 for 2 cycles, then 1, with HRDATA=0xA5A5A5A5.
  - Required: HREADY low for 2 cycles, then HRDATA=0xA5A5A5A5 with HRESP=0. A different HADDR presented during the waits does not change dsel.
- **Unmapped error:** NONSEQ to 0x30000000 → next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1. ERR_ADDR=0x30000000, ERR_CNT=1, ERR_VALID=1.
- **Back-to-back errors and sticky first error**
  - Stimulus: second NONSEQ to 0x50000000 presented during ERR2.
  - Required: ERR1 follows immediately, ERR_CNT=2, ERR_ADDR stays 0x30000000.
  - Then: an IDLE transfer to 0x50000000 gives an OKAY zero-wait response and ERR_CNT stays 2.
- **Clear, saturation and priority**
  - ERR_CLR coinciding with an error entry to 0x60000000 → ERR_CNT=1, ERR_ADDR=0x60000000.
  - 300 consecutive errors with CNT_W=8 → ERR_CNT=255.
  - PORT_EN=5'b11110 → access to 0x00000100 is treated as unmapped.
- **Overlap priority:** BASE_0=BASE_1=0x20000000, MASK=0xFFFF0000 → HSEL=5'b00001 for HADDR=0x20000010.
